flow_fsm_ctrl: RTL and testbench

Parametrised flow-control state machine for the transaction-layer datapath. It programs and holds the almost-full/almost-empty thresholds for each FIFO stage during initialisation. It tracks whether the N datapath FIFOs are idle or active, and latches a sticky error with the identity of the failing FIFO. It sits beside the FIFO stages and drives their threshold inputs and the top-level status pins.

---
 rtl/flow_fsm_ctrl_pkg.sv | 18 +
 rtl/flow_fsm_ctrl_if.sv | 37 +++
 rtl/flow_fsm_ctrl_empty_qualifier.sv | 28 ++
 rtl/flow_fsm_ctrl.sv | 90 +++++++++
 tb/tb_flow_fsm_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_fsm_ctrl_pkg.sv
// flow_fsm_ctrl_pkg: state encodings and width helpers shared by the flow-control FSMs
package flow_fsm_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flow_fsm_ctrl_if.sv
// flow_fsm_ctrl_if: FIFO-side flags, threshold bus and status pins of the flow-control FSM
interface flow_fsm_ctrl_if
    import flow_fsm_ctrl_pkg::*;
#(
    parameter int N_FIFOS = 4,
    parameter int N_TH    = 3,
    parameter int TH_W    = 3
);

    localparam int ID_W = id_width(N_FIFOS);

    logic                   init;
    logic [N_FIFOS-1:0]     errors;
    logic [N_FIFOS-1:0]     empties;
    logic [N_TH*TH_W-1:0]   umbral_in;
    logic [N_TH*TH_W-1:0]   umbral_out;
    logic [STATE_W-1:0]     state_out;
    logic                   init_out;
    logic                   idle_out;
    logic                   active_out;
    logic                   error_out;
    logic [N_FIFOS-1:0]     err_vec_out;
    logic [ID_W-1:0]        err_id_out;

    modport master (
        output init, errors, empties, umbral_in,
        input  umbral_out, state_out, init_out, idle_out, active_out, error_out,
               err_vec_out, err_id_out
    );

    modport slave (
        input  init, errors, empties, umbral_in,
        output umbral_out, state_out, init_out, idle_out, active_out, error_out,
               err_vec_out, err_id_out
    );

endinterface

// File: rtl/flow_fsm_ctrl_empty_qualifier.sv
// empty_qualifier: requires IDLE_DLY consecutive all-empty samples while enabled
module empty_qualifier #(
    parameter int IDLE_DLY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic all_empty,
    output logic qualified
);

    localparam int CW = $clog2(IDLE_DLY + 1);
    localparam logic [CW-1:0] LAST = CW'(IDLE_DLY - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // saturates on the qualifying edge so it can never wrap
    always_comb begin
        cnt_d     = (enable && all_empty) ? ((cnt_q == LAST) ? cnt_q : cnt_q + CW'(1)) : '0;
        qualified = enable && all_empty && (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/flow_fsm_ctrl.sv
// flow_fsm_ctrl: threshold programming, idle/active tracking and sticky error capture for N FIFOs
module flow_fsm_ctrl
    import flow_fsm_ctrl_pkg::*;
#(
    parameter int N_FIFOS  = 4,
    parameter int N_TH     = 3,
    parameter int TH_W     = 3,
    parameter int IDLE_DLY = 2
) (
    input logic           clk,
    input logic           reset,
    flow_fsm_ctrl_if.slave bus
);

    localparam int ID_W = id_width(N_FIFOS);
    localparam int UW   = N_TH * TH_W;

    state_t             state_q, state_d;
    logic [UW-1:0]      umbral_q, umbral_d;
    logic [N_FIFOS-1:0] err_vec_q, err_vec_d;
    logic [ID_W-1:0]    err_id_q, err_id_d;
    logic               any_err, all_empty, qualified, err_entry;

    function automatic logic [ID_W-1:0] lowest_set(input logic [N_FIFOS-1:0] v);
        lowest_set = '0;
        for (int i = N_FIFOS - 1; i >= 0; i--)
            if (v[i]) lowest_set = ID_W'(i);
    endfunction

    assign any_err   = |bus.errors;
    assign all_empty = &bus.empties;
    assign err_entry = (state_q != ST_ERROR) && (state_d == ST_ERROR);

    empty_qualifier #(.IDLE_DLY(IDLE_DLY)) u_qual (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_q == ST_ACTIVE),
        .all_empty (all_empty),
        .qualified (qualified)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    // errors outrank init and activity in every operational state; codes 5-7 fall to RESET
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = bus.init ? ST_INIT : ST_RESET;
            ST_INIT:   state_d = any_err ? ST_ERROR : bus.init ? ST_INIT : ST_IDLE;
            ST_IDLE:   state_d = any_err ? ST_ERROR : bus.init ? ST_INIT :
                                 !all_empty ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_d = any_err ? ST_ERROR : qualified ? ST_IDLE : ST_ACTIVE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        umbral_d  = (state_q == ST_INIT && bus.init) ? bus.umbral_in : umbral_q;
        err_vec_d = err_entry ? bus.errors : err_vec_q;
        err_id_d  = err_entry ? lowest_set(bus.errors) : err_id_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            umbral_q  <= '0;
            err_vec_q <= '0;
            err_id_q  <= '0;
        end else begin
            umbral_q  <= umbral_d;
            err_vec_q <= err_vec_d;
            err_id_q  <= err_id_d;
        end
    end

    always_comb begin
        bus.state_out   = state_q;
        bus.init_out    = state_q == ST_INIT;
        bus.idle_out    = state_q == ST_IDLE;
        bus.active_out  = state_q == ST_ACTIVE;
        bus.error_out   = state_q == ST_ERROR;
        bus.umbral_out  = umbral_q;
        bus.err_vec_out = err_vec_q;
        bus.err_id_out  = err_id_q;
    end

endmodule

// File: tb/tb_flow_fsm_ctrl.sv
// tb_flow_fsm_ctrl: directed and randomized checks of three flow_fsm_ctrl configurations against a rule model
module tb_flow_fsm_ctrl;

    typedef struct packed {
        int         st;
        int         run;
        logic [8:0] umb;
        logic [7:0] vec;
        int         id;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_init, b_init, c_init;
    logic [3:0] a_err, a_emp;
    logic [0:0] b_err, b_emp;
    logic [7:0] c_err, c_emp;
    logic [8:0] a_umb, b_umb, c_umb;

    mstate_t ma, mb, mc;
    int n_checks = 0;
    int n_errs   = 0;

    flow_fsm_ctrl_if #(.N_FIFOS(4), .N_TH(3), .TH_W(3)) a ();
    flow_fsm_ctrl_if #(.N_FIFOS(1), .N_TH(3), .TH_W(3)) b ();
    flow_fsm_ctrl_if #(.N_FIFOS(8), .N_TH(3), .TH_W(3)) c ();

    assign a.init = a_init; assign a.errors = a_err; assign a.empties = a_emp; assign a.umbral_in = a_umb;
    assign b.init = b_init; assign b.errors = b_err; assign b.empties = b_emp; assign b.umbral_in = b_umb;
    assign c.init = c_init; assign c.errors = c_err; assign c.empties = c_emp; assign c.umbral_in = c_umb;

    flow_fsm_ctrl #(.N_FIFOS(4), .N_TH(3), .TH_W(3), .IDLE_DLY(2)) dut_a (.clk(clk), .reset(rst_n), .bus(a));
    flow_fsm_ctrl #(.N_FIFOS(1), .N_TH(3), .TH_W(3), .IDLE_DLY(1)) dut_b (.clk(clk), .reset(rst_n), .bus(b));
    flow_fsm_ctrl #(.N_FIFOS(8), .N_TH(3), .TH_W(3), .IDLE_DLY(1)) dut_c (.clk(clk), .reset(rst_n), .bus(c));

    // states: 0 reset, 1 init, 2 idle, 3 active, 4 error; run counts consecutive all-empty edges
    function automatic mstate_t mstep(mstate_t s, logic rst, logic init, logic [7:0] err,
                                      logic [7:0] emp, logic [8:0] umb, int n, int dly);
        mstate_t r;
        logic [7:0] mask, e, lo;
        logic all;
        mask = 8'((1 << n) - 1);
        e    = err & mask;
        all  = (emp & mask) == mask;
        r    = s;
        if (!rst) return '0;
        case (s.st)
            0: if (init) r.st = 1;
            1: begin
                if (init) r.umb = umb;
                if (e != 0) r.st = 4;
                else if (!init) r.st = 2;
            end
            2: if (e != 0) r.st = 4; else if (init) r.st = 1; else if (!all) r.st = 3;
            3: begin
                if (e != 0) begin r.st = 4; r.run = 0; end
                else if (all) begin
                    r.run = s.run + 1;
                    if (r.run >= dly) begin r.st = 2; r.run = 0; end
                end else r.run = 0;
            end
            default: ;
        endcase
        if (r.st == 4 && s.st != 4) begin
            lo    = e & (~e + 8'd1);
            r.vec = e;
            r.id  = $countones(lo - 8'd1);
        end
        return r;
    endfunction

    function automatic logic [27:0] expv(mstate_t s);
        return {s.st[2:0], s.st == 1, s.st == 2, s.st == 3, s.st == 4, s.vec, s.id[3:0], s.umb};
    endfunction

    function automatic logic [27:0] obs_a();
        return {a.state_out, a.init_out, a.idle_out, a.active_out, a.error_out,
                4'b0, a.err_vec_out, 2'b0, a.err_id_out, a.umbral_out};
    endfunction

    function automatic logic [27:0] obs_b();
        return {b.state_out, b.init_out, b.idle_out, b.active_out, b.error_out,
                7'b0, b.err_vec_out, 3'b0, b.err_id_out, b.umbral_out};
    endfunction

    function automatic logic [27:0] obs_c();
        return {c.state_out, c.init_out, c.idle_out, c.active_out, c.error_out,
                c.err_vec_out, 1'b0, c.err_id_out, c.umbral_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        ma = mstep(ma, rst_n, a_init, {4'b0, a_err}, {4'b0, a_emp}, a_umb, 4, 2);
        mb = mstep(mb, rst_n, b_init, {7'b0, b_err}, {7'b0, b_emp}, b_umb, 1, 1);
        mc = mstep(mc, rst_n, c_init, c_err, c_emp, c_umb, 8, 1);
        #1;
    endtask

    task automatic go_idle_a();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; a_init = 1'b1; tick(); tick();
        a_init = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs_a() !== 28'h0) begin n_errs++; $display("FAIL reset_a: got %h expected %h", obs_a(), 28'h0); end
        n_checks++;
        if (obs_b() !== expv(mb)) begin n_errs++; $display("FAIL reset_b: got %h expected %h", obs_b(), expv(mb)); end
        n_checks++;
        if (obs_c() !== expv(mc)) begin n_errs++; $display("FAIL reset_c: got %h expected %h", obs_c(), expv(mc)); end
    endtask

    task automatic test_init_load();
        rst_n = 1'b1; a_init = 1'b1; a_umb = 9'o123;
        tick();
        n_checks++;
        if (a.state_out !== 3'd1) begin n_errs++; $display("FAIL init_enter: got %0d expected 1", a.state_out); end
        tick();
        n_checks++;
        if (a.umbral_out !== 9'o123) begin n_errs++; $display("FAIL init_load1: got %o expected 123", a.umbral_out); end
        a_umb = 9'o456;
        tick();
        a_init = 1'b0; a_umb = 9'o777;
        tick();
        n_checks++;
        if ({a.state_out, a.umbral_out} !== {3'd2, 9'o456}) begin
            n_errs++; $display("FAIL init_to_idle: got %0d/%o expected 2/456", a.state_out, a.umbral_out);
        end
        n_checks++;
        if (obs_a() !== expv(ma)) begin n_errs++; $display("FAIL init_model: got %h expected %h", obs_a(), expv(ma)); end
    endtask

    task automatic test_idle_qual();
        logic [3:0] pat [4] = '{4'hF, 4'h7, 4'hF, 4'hF};
        int         est [4] = '{3, 3, 3, 2};
        a_emp = 4'h0;
        tick();
        n_checks++;
        if (a.state_out !== 3'd3) begin n_errs++; $display("FAIL to_active: got %0d expected 3", a.state_out); end
        for (int i = 0; i < 4; i++) begin
            a_emp = pat[i];
            tick();
            n_checks++;
            if (a.state_out !== est[i][2:0]) begin
                n_errs++; $display("FAIL idle_qual[%0d]: got %0d expected %0d", i, a.state_out, est[i]);
            end
            n_checks++;
            if (obs_a() !== expv(ma)) begin n_errs++; $display("FAIL idle_qual_model[%0d]: got %h expected %h", i, obs_a(), expv(ma)); end
        end
        n_checks++;
        if (a.umbral_out !== 9'o456) begin n_errs++; $display("FAIL umbral_hold: got %o expected 456", a.umbral_out); end
    endtask

    task automatic test_active_init_ignored();
        a_emp = 4'h0;
        tick();
        a_init = 1'b1; a_umb = 9'o111;
        tick(); tick();
        n_checks++;
        if ({a.state_out, a.umbral_out} !== {3'd3, 9'o456}) begin
            n_errs++; $display("FAIL active_init: got %0d/%o expected 3/456", a.state_out, a.umbral_out);
        end
        a_init = 1'b0;
    endtask

    task automatic test_error_capture();
        logic [3:0] seq [4] = '{4'b1010, 4'b0000, 4'b0101, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            a_err = seq[i];
            a_emp = (i == 3) ? 4'hF : 4'h0;
            tick();
            n_checks++;
            if ({a.state_out, a.error_out, a.err_vec_out, a.err_id_out} !== {3'd4, 1'b1, 4'b1010, 2'd1}) begin
                n_errs++;
                $display("FAIL err_hold[%0d]: got st=%0d vec=%b id=%0d expected st=4 vec=1010 id=1",
                         i, a.state_out, a.err_vec_out, a.err_id_out);
            end
            n_checks++;
            if (obs_a() !== expv(ma)) begin n_errs++; $display("FAIL err_model[%0d]: got %h expected %h", i, obs_a(), expv(ma)); end
        end
    endtask

    task automatic test_reset_mid_active();
        go_idle_a();
        a_emp = 4'h0; tick();
        a_emp = 4'hF; tick();
        n_checks++;
        if (a.state_out !== 3'd3) begin n_errs++; $display("FAIL one_empty_stays: got %0d expected 3", a.state_out); end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (obs_a() !== 28'h0) begin n_errs++; $display("FAIL reset_mid_active: got %h expected %h", obs_a(), 28'h0); end
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        go_idle_a();
        a_err = 4'b0001; a_init = 1'b1;
        tick();
        n_checks++;
        if ({a.state_out, a.err_vec_out, a.err_id_out} !== {3'd4, 4'b0001, 2'd0}) begin
            n_errs++; $display("FAIL err_over_init: got st=%0d vec=%b id=%0d expected st=4 vec=0001 id=0",
                               a.state_out, a.err_vec_out, a.err_id_out);
        end
        a_err = 4'b0; a_init = 1'b0;
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 6; k++) begin
            rst_n = 1'b0; tick();
            rst_n = 1'b1; b_init = 1'b1; c_init = 1'b1; tick(); tick();
            b_init = 1'b0; c_init = 1'b0; tick();
            b_emp = 1'b0; c_emp = 8'($urandom_range(0, 254));
            tick();
            n_checks++;
            if ({b.state_out, c.state_out} !== {3'd3, 3'd3}) begin
                n_errs++; $display("FAIL sweep_active[%0d]: got %0d/%0d expected 3/3", k, b.state_out, c.state_out);
            end
            b_emp = 1'b1; c_emp = 8'hFF;
            tick();
            n_checks++;
            if ({b.state_out, c.state_out} !== {3'd2, 3'd2}) begin
                n_errs++; $display("FAIL sweep_idle[%0d]: got %0d/%0d expected 2/2", k, b.state_out, c.state_out);
            end
            b_err = 1'b1; c_err = 8'($urandom_range(1, 255));
            tick();
            b_err = 1'b0; c_err = 8'h0;
            n_checks++;
            if (obs_b() !== expv(mb)) begin n_errs++; $display("FAIL sweep_b[%0d]: got %h expected %h", k, obs_b(), expv(mb)); end
            n_checks++;
            if (obs_c() !== expv(mc)) begin n_errs++; $display("FAIL sweep_c[%0d]: got %h expected %h", k, obs_c(), expv(mc)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n  = $urandom_range(0, 39) != 0;
            a_init = $urandom_range(0, 3) == 0;
            b_init = $urandom_range(0, 3) == 0;
            c_init = $urandom_range(0, 3) == 0;
            a_err  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            b_err  = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            c_err  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h0;
            a_emp  = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            b_emp  = 1'($urandom);
            c_emp  = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            a_umb  = 9'($urandom); b_umb = 9'($urandom); c_umb = 9'($urandom);
            tick();
            n_checks++;
            if (obs_a() !== expv(ma)) begin n_errs++; $display("FAIL rand_a[%0d]: got %h expected %h", i, obs_a(), expv(ma)); end
            n_checks++;
            if (obs_b() !== expv(mb)) begin n_errs++; $display("FAIL rand_b[%0d]: got %h expected %h", i, obs_b(), expv(mb)); end
            n_checks++;
            if (obs_c() !== expv(mc)) begin n_errs++; $display("FAIL rand_c[%0d]: got %h expected %h", i, obs_c(), expv(mc)); end
        end
    endtask

    initial begin
        ma = '0; mb = '0; mc = '0;
        rst_n = 1'b0;
        a_init = 1'b0; b_init = 1'b0; c_init = 1'b0;
        a_err = '0; b_err = '0; c_err = '0;
        a_emp = '1; b_emp = '1; c_emp = '1;
        a_umb = '0; b_umb = '0; c_umb = '0;
        test_reset();
        test_init_load();
        test_idle_qual();
        test_active_init_ignored();
        test_error_capture();
        test_reset_mid_active();
        test_priority();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
